sm_rd_sched: RTL and testbench
==============================

Name: sm_rd_sched

Overview:
Read-side scheduler downstream of the shared-memory packet buffer. Consumes the per-packet result stream (sm_res_t) from the write side and queues the descriptors in an internal FIFO. Converts each descriptor into a read-side command (sm_cmd_t): READ for good packets, FREE for errored packets. Throttles READs against a limit on packets in flight, tracked by watching end-of-packet handshakes on the buffer's output stream.

Parameters:
DEPTH, 16, descriptor FIFO entries; power of two, >= 2
MAX_OUTSTANDING, 4, max READ commands issued whose packet eop has not yet been seen; 1..255
CNT_W, 32, width of optional statistics counters

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
sm_res_data_i  in  sm_res_t  descriptor; fields used: ptr, len, err
sm_res_valid_i  in  1  descriptor valid
sm_res_ready_o  out  1  descriptor accepted when valid&ready
sm_cmd_data_o  out  sm_cmd_t  command; fields: opcode (SM_CMD_READ/SM_CMD_FREE), ptr, len
sm_cmd_valid_o  out  1  command valid
sm_cmd_ready_i  in  1  command accepted when valid&ready
mon_eop_i  in  1  one-cycle pulse = ast_src valid&ready&eop of buffer output
fifo_used_o  out  $clog2(DEPTH)+1  descriptors currently queued
outstanding_o  out  8  READs in flight
underflow_err_o  out  1  sticky: mon_eop_i seen with outstanding==0

Behaviour:
- Reset: sm_res_ready_o=0 during rst_i, 1 on first cycle after (FIFO empty); sm_cmd_valid_o=0, sm_cmd_data_o=0, fifo_used_o=0, outstanding_o=0, underflow_err_o=0. FIFO pointers cleared; stored entries discarded; a command held mid-handshake is dropped.
- FIFO: circular, wr/rd pointers of $clog2(DEPTH)+1 bits (extra wrap bit); full when low bits equal and wrap bits differ; empty when pointers equal.
- sm_res_ready_o = !full (registered-free combinational from pointers); no write-through when full. Push on sm_res_valid_i&sm_res_ready_o.
- Output register stage: FSM with states IDLE, HOLD.
  - IDLE: sm_cmd_valid_o=0. If FIFO non-empty and head may issue -> load head into output register, pop, go HOLD.
  - Head may issue: head.err=1 (FREE, never throttled) or outstanding < MAX_OUTSTANDING (READ).
  - HOLD: sm_cmd_valid_o=1, data stable until sm_cmd_ready_i. On handshake: if FIFO non-empty and next head may issue (counting the READ just accepted) -> reload same cycle, stay HOLD (back-to-back, 1 cmd/clk); else -> IDLE.
- Latency: descriptor pushed into empty FIFO in cycle N -> sm_cmd_valid_o high in cycle N+2 (FIFO write N, load N+1, visible N+2). No combinational res->cmd path.
- Command mapping: opcode = err ? SM_CMD_FREE : SM_CMD_READ; ptr, len copied unchanged.
- Outstanding counter: +1 on READ handshake, -1 on mon_eop_i; both same cycle -> unchanged. mon_eop_i at 0 with no increment -> stays 0, underflow_err_o set (cleared only by reset). Never exceeds MAX_OUTSTANDING.
- fifo_used_o = wr_ptr - rd_ptr, in range 0..DEPTH.
- Ordering: commands issued strictly in descriptor arrival order; a throttled READ at the head blocks later FREEs (no bypass).

Optional Feature:
SM_RD_SCHED_STATS_EN: when defined, adds outputs stat_read_cnt_o, stat_free_cnt_o, stat_eop_cnt_o (CNT_W each). Each counts its handshakes (READ cmd, FREE cmd, mon_eop_i), saturates at all-ones and resets to 0. When undefined, these ports and their logic are absent; all other behaviour is identical.

Test Plan:
- Reset then 3 good descriptors (ptr 0x10/0x20/0x30, len 64), cmd_ready=1 -> 3 READ cmds in order, first at push+2, then back-to-back; outstanding_o=3.
- MAX_OUTSTANDING=4, 6 good descriptors, no mon_eop_i -> exactly 4 READs issued, sm_cmd_valid_o low; one mon_eop_i pulse -> 5th READ issued within 2 cycles.
- Outstanding=4 with head err=0 followed by err=1 -> FREE not issued until a mon_eop_i frees a slot (no bypass).
- DEPTH=16, cmd_ready=0, push 17 -> 16 accepted, sm_res_ready_o=0, fifo_used_o=16; sm_cmd_data_o stable while valid&!ready.
- mon_eop_i with outstanding=0 -> underflow_err_o=1, outstanding_o stays 0; READ handshake and mon_eop_i in the same cycle -> count unchanged.
- rst_i asserted in HOLD with 5 queued -> next cycle sm_cmd_valid_o=0, fifo_used_o=0, outstanding_o=0; with SM_RD_SCHED_STATS_EN, counters=0.

Source files
------------

// File: rtl/sm_rd_sched.sv
// Read-side scheduler: queues write-side packet results and issues READ/FREE commands, throttling READs by packets in flight.
// Optional statistics outputs are enabled by defining SM_RD_SCHED_STATS_EN.
package sm_rd_sched_pkg;
  localparam int unsigned SM_PTR_W = 16;
  localparam int unsigned SM_LEN_W = 16;

  typedef logic [1:0] sm_opcode_t;
  localparam sm_opcode_t SM_CMD_READ = 2'd1;
  localparam sm_opcode_t SM_CMD_FREE = 2'd2;

  typedef struct packed {
    logic [SM_PTR_W-1:0] ptr;
    logic [SM_LEN_W-1:0] len;
    logic                err;
  } sm_res_t;

  typedef struct packed {
    sm_opcode_t          opcode;
    logic [SM_PTR_W-1:0] ptr;
    logic [SM_LEN_W-1:0] len;
  } sm_cmd_t;
endpackage

module sm_rd_sched
  import sm_rd_sched_pkg::*;
#(
  parameter int unsigned DEPTH           = 16,
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter int unsigned CNT_W           = 32
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  sm_res_t                  sm_res_data_i,
  input  logic                     sm_res_valid_i,
  output logic                     sm_res_ready_o,
  output sm_cmd_t                  sm_cmd_data_o,
  output logic                     sm_cmd_valid_o,
  input  logic                     sm_cmd_ready_i,
  input  logic                     mon_eop_i,
  output logic [$clog2(DEPTH):0]   fifo_used_o,
  output logic [7:0]               outstanding_o,
  output logic                     underflow_err_o
`ifdef SM_RD_SCHED_STATS_EN
  ,
  output logic [CNT_W-1:0]         stat_read_cnt_o,
  output logic [CNT_W-1:0]         stat_free_cnt_o,
  output logic [CNT_W-1:0]         stat_eop_cnt_o
`endif
);

  localparam int unsigned AW = $clog2(DEPTH);

  typedef enum logic {ST_IDLE, ST_HOLD} state_t;

  sm_res_t     r_mem [DEPTH];
  logic [AW:0] r_wr_ptr, r_rd_ptr;
  state_t      r_state, w_state_nxt;
  sm_cmd_t     r_cmd;
  logic [7:0]  r_outstanding;
  logic        r_underflow;

  logic        w_full, w_empty, w_push, w_pop;
  logic        w_cmd_hs, w_read_hs, w_may_issue;
  logic [8:0]  w_out_eff;
  sm_res_t     w_head;

  assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_head  = r_mem[r_rd_ptr[AW-1:0]];

  assign sm_res_ready_o  = !w_full && !rst_i;
  assign w_push          = sm_res_valid_i && sm_res_ready_o;
  assign sm_cmd_valid_o  = (r_state == ST_HOLD);
  assign sm_cmd_data_o   = r_cmd;
  assign w_cmd_hs        = sm_cmd_valid_o && sm_cmd_ready_i;
  assign w_read_hs       = w_cmd_hs && (r_cmd.opcode == SM_CMD_READ);
  assign fifo_used_o     = r_wr_ptr - r_rd_ptr;
  assign outstanding_o   = r_outstanding;
  assign underflow_err_o = r_underflow;

  // The READ accepted this cycle already counts against the limit for a back-to-back reload.
  assign w_out_eff   = {1'b0, r_outstanding} + {8'd0, w_read_hs};
  assign w_may_issue = !w_empty && (w_head.err || (w_out_eff < 9'(MAX_OUTSTANDING)));

  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_may_issue) begin
          w_pop       = 1'b1;
          w_state_nxt = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (w_cmd_hs) begin
          if (w_may_issue) w_pop = 1'b1;
          else             w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= sm_res_data_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_state       <= ST_IDLE;
      r_cmd         <= '0;
      r_outstanding <= '0;
      r_underflow   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop) begin
        r_rd_ptr     <= r_rd_ptr + 1'b1;
        r_cmd.opcode <= w_head.err ? SM_CMD_FREE : SM_CMD_READ;
        r_cmd.ptr    <= w_head.ptr;
        r_cmd.len    <= w_head.len;
      end
      if (w_read_hs && !mon_eop_i) begin
        r_outstanding <= r_outstanding + 1'b1;
      end else if (mon_eop_i && !w_read_hs) begin
        if (r_outstanding == '0) r_underflow   <= 1'b1;
        else                     r_outstanding <= r_outstanding - 1'b1;
      end
    end
  end

`ifdef SM_RD_SCHED_STATS_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stat_read_cnt_o <= '0;
      stat_free_cnt_o <= '0;
      stat_eop_cnt_o  <= '0;
    end else begin
      if (w_read_hs && !(&stat_read_cnt_o))
        stat_read_cnt_o <= stat_read_cnt_o + 1'b1;
      if (w_cmd_hs && !w_read_hs && !(&stat_free_cnt_o))
        stat_free_cnt_o <= stat_free_cnt_o + 1'b1;
      if (mon_eop_i && !(&stat_eop_cnt_o))
        stat_eop_cnt_o <= stat_eop_cnt_o + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_sm_rd_sched.sv
// Self-checking bench for sm_rd_sched: directed scenarios plus randomized traffic against a queue-based model.
module tb_sm_rd_sched;
  import sm_rd_sched_pkg::*;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned MAXO  = 4;
  localparam int unsigned CNT_W = 32;
  localparam int unsigned UW    = $clog2(DEPTH) + 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_i;
  sm_res_t       sm_res_data_i;
  logic          sm_res_valid_i, sm_res_ready_o;
  sm_cmd_t       sm_cmd_data_o;
  logic          sm_cmd_valid_o, sm_cmd_ready_i;
  logic          mon_eop_i;
  logic [UW-1:0] fifo_used_o;
  logic [7:0]    outstanding_o;
  logic          underflow_err_o;
`ifdef SM_RD_SCHED_STATS_EN
  logic [CNT_W-1:0] stat_read_cnt_o, stat_free_cnt_o, stat_eop_cnt_o;
`endif

  sm_rd_sched #(.DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO), .CNT_W(CNT_W)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .sm_res_data_i(sm_res_data_i), .sm_res_valid_i(sm_res_valid_i), .sm_res_ready_o(sm_res_ready_o),
    .sm_cmd_data_o(sm_cmd_data_o), .sm_cmd_valid_o(sm_cmd_valid_o), .sm_cmd_ready_i(sm_cmd_ready_i),
    .mon_eop_i(mon_eop_i), .fifo_used_o(fifo_used_o), .outstanding_o(outstanding_o),
    .underflow_err_o(underflow_err_o)
`ifdef SM_RD_SCHED_STATS_EN
    , .stat_read_cnt_o(stat_read_cnt_o), .stat_free_cnt_o(stat_free_cnt_o), .stat_eop_cnt_o(stat_eop_cnt_o)
`endif
  );

  int      n_cmp = 0;
  int      n_fail = 0;
  sm_res_t pend[$];
  int      m_out, stall;
  bit      m_uf;
  bit      prev_hold;
  sm_cmd_t prev_cmd;
  int      n_push, n_read, n_free;
  longint  m_st_rd, m_st_fr, m_st_eop;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic sm_res_t mk(input logic [15:0] p, input logic [15:0] l, input logic e);
    sm_res_t r;
    r.ptr = p; r.len = l; r.err = e;
    return r;
  endfunction

  task automatic model_clear();
    pend.delete();
    m_out = 0; m_uf = 0; stall = 0; prev_hold = 0;
    m_st_rd = 0; m_st_fr = 0; m_st_eop = 0;
  endtask

  // One clock: capture handshakes before the edge, then update the model and check after it.
  task automatic cycle();
    bit      push, hs, eop, hold, is_read;
    sm_res_t rd;
    sm_cmd_t cd;
    sm_res_t exp;
    push = sm_res_valid_i && sm_res_ready_o;
    rd   = sm_res_data_i;
    hs   = sm_cmd_valid_o && sm_cmd_ready_i;
    hold = sm_cmd_valid_o && !sm_cmd_ready_i;
    cd   = sm_cmd_data_o;
    eop  = mon_eop_i;
    is_read = 1'b0;
    @(posedge clk); #1;
    if (hs) begin
      if (pend.size() == 0) begin
        chk("unexpected_cmd", 1, 0);
      end else begin
        exp = pend.pop_front();
        is_read = !exp.err;
        chk("cmd_opcode", 64'(cd.opcode), exp.err ? 64'(SM_CMD_FREE) : 64'(SM_CMD_READ));
        chk("cmd_ptr", 64'(cd.ptr), 64'(exp.ptr));
        chk("cmd_len", 64'(cd.len), 64'(exp.len));
        if (is_read) begin
          chk("read_throttle", 64'(m_out < int'(MAXO)), 1);
          n_read++; m_st_rd++;
        end else begin
          n_free++; m_st_fr++;
        end
      end
    end
    if (push) begin
      pend.push_back(rd);
      n_push++;
    end
    if (eop) m_st_eop++;
    if (is_read && !eop) m_out++;
    else if (eop && !is_read) begin
      if (m_out == 0) m_uf = 1'b1;
      else m_out--;
    end
    if (hold) begin
      chk("hold_valid", 64'(sm_cmd_valid_o), 1);
      chk("hold_data", 64'(sm_cmd_data_o), 64'(cd));
    end
    chk("outstanding", 64'(outstanding_o), 64'(m_out));
    chk("underflow", 64'(underflow_err_o), 64'(m_uf));
    chk("used_plus_held", 64'(fifo_used_o) + 64'(sm_cmd_valid_o), 64'(pend.size()));
    if (!sm_cmd_valid_o && pend.size() > 0 && (pend[0].err || m_out < int'(MAXO))) stall++;
    else stall = 0;
    chk("issue_stall", 64'(stall <= 1), 1);
`ifdef SM_RD_SCHED_STATS_EN
    chk("stat_read", 64'(stat_read_cnt_o), 64'(m_st_rd));
    chk("stat_free", 64'(stat_free_cnt_o), 64'(m_st_fr));
    chk("stat_eop", 64'(stat_eop_cnt_o), 64'(m_st_eop));
`endif
  endtask

  task automatic reset_dut();
    rst_i = 1'b1; sm_res_valid_i = 1'b0; sm_res_data_i = '0;
    sm_cmd_ready_i = 1'b0; mon_eop_i = 1'b0;
    @(posedge clk); #1;
    chk("rst_res_ready", 64'(sm_res_ready_o), 0);
    chk("rst_cmd_valid", 64'(sm_cmd_valid_o), 0);
    chk("rst_cmd_data", 64'(sm_cmd_data_o), 0);
    chk("rst_used", 64'(fifo_used_o), 0);
    chk("rst_outstanding", 64'(outstanding_o), 0);
    chk("rst_underflow", 64'(underflow_err_o), 0);
`ifdef SM_RD_SCHED_STATS_EN
    chk("rst_stat_read", 64'(stat_read_cnt_o), 0);
    chk("rst_stat_free", 64'(stat_free_cnt_o), 0);
    chk("rst_stat_eop", 64'(stat_eop_cnt_o), 0);
`endif
    @(posedge clk); #1;
    rst_i = 1'b0;
    #1;
    chk("post_rst_res_ready", 64'(sm_res_ready_o), 1);
    model_clear();
  endtask

  task automatic push_one(input sm_res_t d);
    sm_res_data_i = d; sm_res_valid_i = 1'b1;
    cycle();
    sm_res_valid_i = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic drain();
    bit done;
    done = 0;
    sm_cmd_ready_i = 1'b1; sm_res_valid_i = 1'b0;
    for (int i = 0; i < 300 && !done; i++) begin
      mon_eop_i = (m_out > 0);
      cycle();
      done = (pend.size() == 0 && m_out == 0);
    end
    mon_eop_i = 1'b0;
    chk("drain_done", 64'(done), 1);
  endtask

  initial begin
    bit found;
    sm_cmd_t cap;
    int base_rd, base_fr, base_push;
    n_push = 0; n_read = 0; n_free = 0;
    model_clear();
    reset_dut();

    // Three good descriptors: first command at push+2, then back-to-back.
    sm_cmd_ready_i = 1'b1;
    sm_res_valid_i = 1'b1;
    sm_res_data_i = mk(16'h10, 16'd64, 1'b0); cycle();
    chk("lat_not_yet", 64'(sm_cmd_valid_o), 0);
    sm_res_data_i = mk(16'h20, 16'd64, 1'b0); cycle();
    chk("lat_valid", 64'(sm_cmd_valid_o), 1);
    chk("first_ptr", 64'(sm_cmd_data_o.ptr), 64'h10);
    sm_res_data_i = mk(16'h30, 16'd64, 1'b0); cycle();
    sm_res_valid_i = 1'b0;
    chk("b2b_ptr2", 64'(sm_cmd_data_o.ptr), 64'h20);
    cycle();
    chk("b2b_ptr3", 64'(sm_cmd_data_o.ptr), 64'h30);
    idle(2);
    chk("three_outstanding", 64'(outstanding_o), 3);
    chk("three_idle", 64'(sm_cmd_valid_o), 0);

    // Throttle at MAX_OUTSTANDING, then release with a single eop.
    mon_eop_i = 1'b1; idle(3); mon_eop_i = 1'b0;
    base_rd = n_read;
    for (int i = 0; i < 6; i++) push_one(mk(16'(16'h100 + i), 16'd128, 1'b0));
    idle(12);
    chk("throttle_reads", 64'(n_read - base_rd), 64'(MAXO));
    chk("throttle_valid", 64'(sm_cmd_valid_o), 0);
    chk("throttle_used", 64'(fifo_used_o), 2);
    mon_eop_i = 1'b1; cycle(); mon_eop_i = 1'b0;
    found = 0;
    for (int i = 0; i < 2 && !found; i++) begin
      cycle();
      found = sm_cmd_valid_o;
    end
    chk("eop_release", 64'(found), 1);
    idle(3);
    chk("fifth_read", 64'(n_read - base_rd), 64'(MAXO + 1));

    // FREE behind a throttled READ must wait.
    base_fr = n_free;
    push_one(mk(16'h2ff, 16'd32, 1'b1));
    idle(8);
    chk("no_bypass_valid", 64'(sm_cmd_valid_o), 0);
    chk("no_bypass_free", 64'(n_free - base_fr), 0);
    chk("no_bypass_used", 64'(fifo_used_o), 2);
    mon_eop_i = 1'b1; cycle(); mon_eop_i = 1'b0;
    idle(6);
    chk("free_after_eop", 64'(n_free - base_fr), 1);
    chk("out_after_free", 64'(outstanding_o), 64'(MAXO));
    drain();

    // Fill the FIFO while the output stage is throttled.
    for (int i = 0; i < int'(MAXO); i++) push_one(mk(16'(16'h300 + i), 16'd16, 1'b0));
    idle(8);
    chk("full_pre_out", 64'(outstanding_o), 64'(MAXO));
    sm_cmd_ready_i = 1'b0;
    base_push = n_push;
    sm_res_valid_i = 1'b1;
    for (int i = 0; i < int'(DEPTH) + 1; i++) begin
      sm_res_data_i = mk(16'(16'h400 + i), 16'(i), 1'b0);
      cycle();
    end
    sm_res_valid_i = 1'b0;
    chk("full_accepted", 64'(n_push - base_push), 64'(DEPTH));
    chk("full_ready", 64'(sm_res_ready_o), 0);
    chk("full_used", 64'(fifo_used_o), 64'(DEPTH));
    mon_eop_i = 1'b1; cycle(); mon_eop_i = 1'b0;
    cycle();
    chk("stall_valid", 64'(sm_cmd_valid_o), 1);
    cap = sm_cmd_data_o;
    chk("stall_head_ptr", 64'(cap.ptr), 64'h400);
    for (int i = 0; i < 4; i++) begin
      cycle();
      chk("stall_stable", 64'(sm_cmd_data_o), 64'(cap));
    end
    drain();

    // Underflow, then READ handshake coincident with eop.
    mon_eop_i = 1'b1; cycle(); mon_eop_i = 1'b0;
    chk("uf_flag", 64'(underflow_err_o), 1);
    chk("uf_out_zero", 64'(outstanding_o), 0);
    sm_cmd_ready_i = 1'b1;
    push_one(mk(16'h500, 16'd8, 1'b0));
    idle(4);
    chk("coinc_pre", 64'(outstanding_o), 1);
    sm_cmd_ready_i = 1'b0;
    push_one(mk(16'h510, 16'd8, 1'b0));
    idle(3);
    chk("coinc_held", 64'(sm_cmd_valid_o), 1);
    sm_cmd_ready_i = 1'b1; mon_eop_i = 1'b1;
    cycle();
    mon_eop_i = 1'b0;
    chk("coinc_out", 64'(outstanding_o), 1);
    drain();

    // Randomized traffic.
    for (int i = 0; i < 2000; i++) begin
      sm_res_valid_i = ($urandom_range(0, 2) != 0);
      sm_res_data_i  = mk(16'($urandom), 16'($urandom), ($urandom_range(0, 3) == 0));
      sm_cmd_ready_i = ($urandom_range(0, 3) != 0);
      mon_eop_i      = (m_out > 0) && ($urandom_range(0, 2) == 0);
      cycle();
    end
    drain();

    // Reset while holding a command with five descriptors queued.
    sm_cmd_ready_i = 1'b0;
    for (int i = 0; i < 6; i++) push_one(mk(16'(16'h600 + i), 16'd4, 1'b0));
    idle(2);
    chk("pre_rst_valid", 64'(sm_cmd_valid_o), 1);
    chk("pre_rst_used", 64'(fifo_used_o), 5);
    reset_dut();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
